// File: rtl/rf_sample_arbiter.sv
// rf_sample_arbiter: round-robin sharing of one synchronous-read RF sample
// memory port between NREQ requesters. One read per cycle, response one
// cycle later tagged with a one-hot valid. Out-of-range indices are still
// granted, so the requester never stalls, but they do not touch the memory.
module rf_sample_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 24100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int unsigned PtrW = $clog2(NREQ);

    logic [PtrW-1:0]   ptr_q;
    logic [PtrW-1:0]   ptr_d;
    logic [NREQ-1:0]   rsp_valid_q;
    logic              rsp_err_q;

    logic              found;
    int unsigned       idx;
    logic [PtrW-1:0]   win_idx;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic              in_range;

    // Search req from the pointer, wrapping; no grant while reset is held so
    // a transfer coinciding with reset is dropped rather than half-issued.
    always_comb begin
        found   = 1'b0;
        idx     = 0;
        win_idx = '0;
        gnt     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found && req[idx[PtrW-1:0]]) begin
                found   = 1'b1;
                win_idx = idx[PtrW-1:0];
            end
        end
        if (found && !reset) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Winner's address onto the memory port; zero when nothing transfers
    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        xfer     = |gnt;
        in_range = 32'(win_addr) < MEM_DEPTH;
        mem_en   = xfer && in_range;
        mem_addr = win_addr;
    end

    // Pointer moves just past the winner on a transfer, else holds
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = PtrW'((32'(win_idx) + 1) % NREQ);
        end
    end

    // Pointer and response tag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= gnt;
            rsp_err_q   <= xfer && !in_range;
        end
    end

    // Response outputs; data forced to zero when idle or out of range
    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_data  = ((|rsp_valid_q) && !rsp_err_q) ? mem_rdata : '0;
        busy      = (|req) || (|rsp_valid_q);
    end

endmodule

// File: tb/tb_rf_sample_arbiter.sv
// Self-checking bench for rf_sample_arbiter: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_rf_sample_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int DEPTH = 24100;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    gnt;
    logic               mem_en;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_rdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               busy;

    rf_sample_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample contents as a pure function of the index
    function automatic logic [DW-1:0] content(input int a);
        return DW'((a * 37 + 5) ^ (a >> 3));
    endfunction

    // Synchronous-read memory model
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= content(int'(mem_addr));
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus state
    logic [NREQ-1:0] req_v;
    int              addr_a[NREQ];

    // Reference model state
    int              m_ptr;
    logic [NREQ-1:0] m_rv;
    logic            m_re;
    logic [DW-1:0]   m_rd;
    int              e_win;
    logic [NREQ-1:0] e_gnt;
    logic            e_en;
    logic [AW-1:0]   e_addr;

    task automatic drive();
        req = req_v;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = AW'(addr_a[i]);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_rv  = '0;
        m_re  = 1'b0;
        m_rd  = '0;
    endtask

    // Winner = requesting index at the smallest circular distance from the pointer
    task automatic eval_model();
        int best;
        best   = NREQ;
        e_win  = -1;
        e_gnt  = '0;
        e_en   = 1'b0;
        e_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            int d;
            d = (i - m_ptr + NREQ) % NREQ;
            if (req_v[i] && d < best) begin
                best  = d;
                e_win = i;
            end
        end
        if (e_win >= 0) begin
            e_gnt[e_win] = 1'b1;
            e_addr       = AW'(addr_a[e_win]);
            e_en         = addr_a[e_win] < DEPTH;
        end
    endtask

    // Clock edge: the model takes the transfer seen this cycle
    task automatic advance();
        @(posedge clk);
        if (e_win >= 0) begin
            m_rv  = NREQ'(1 << e_win);
            m_re  = !e_en;
            m_rd  = e_en ? content(addr_a[e_win]) : '0;
            m_ptr = (e_win + 1) % NREQ;
        end else begin
            m_rv = '0;
            m_re = 1'b0;
            m_rd = '0;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_v = '0;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_v = '0;
        for (int i = 0; i < NREQ; i++) addr_a[i] = 0;
        drive();
        #3;
        n_checks += 4;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
        end
        if (rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err);
        end
        if (gnt !== 4'b0000 || mem_en !== 1'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_port: gnt %b en %b addr %0d expected 0", gnt, mem_en, mem_addr);
        end
        if (dut.ptr_q !== 2'd0) begin
            n_fail++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        req_v = '0;
        drive();
        for (int c = 0; c < 5; c++) begin
            #3;
            eval_model();
            n_checks++;
            if (gnt !== 4'b0 || mem_en !== 1'b0 || mem_addr !== '0 || rsp_valid !== 4'b0
                || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle c%0d: gnt %b en %b addr %0d rv %b busy %b expected all 0",
                         c, gnt, mem_en, mem_addr, rsp_valid, busy);
            end
            advance();
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 5; c++) begin
            req_v     = (c < 4) ? 4'b0100 : 4'b0000;
            addr_a[2] = 10 + c;
            drive();
            #3;
            eval_model();
            n_checks += 3;
            if (gnt !== ((c < 4) ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL single_gnt c%0d: got %b", c, gnt);
            end
            if (c < 4 && (mem_addr !== AW'(10 + c) || mem_en !== 1'b1)) begin
                n_fail++;
                $display("FAIL single_mem c%0d: addr %0d en %b expected %0d 1",
                         c, mem_addr, mem_en, 10 + c);
            end
            if (c >= 1 && (rsp_valid !== 4'b0100 || rsp_data !== content(9 + c))) begin
                n_fail++;
                $display("FAIL single_rsp c%0d: rv %b data %h expected 0100 %h",
                         c, rsp_valid, rsp_data, content(9 + c));
            end
            advance();
        end
        n_checks++;
        if (dut.ptr_q !== 2'd3) begin
            n_fail++; $display("FAIL single_ptr: got %0d expected 3", dut.ptr_q);
        end
    endtask

    task automatic test_all_requesters();
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            req_v = (c < 8) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < NREQ; i++) addr_a[i] = int'($urandom_range(0, DEPTH - 1));
            drive();
            #3;
            eval_model();
            n_checks += 2;
            if (c < 8 && gnt !== 4'(1 << (c % 4))) begin
                n_fail++;
                $display("FAIL all_gnt c%0d: got %b expected %b", c, gnt, 4'(1 << (c % 4)));
            end
            if ((c == 0 && rsp_valid !== 4'b0) ||
                (c > 0 && (rsp_valid !== 4'(1 << ((c - 1) % 4)) || rsp_data !== m_rd))) begin
                n_fail++;
                $display("FAIL all_rsp c%0d: rv %b data %h expected data %h",
                         c, rsp_valid, rsp_data, m_rd);
            end
            advance();
        end
    endtask

    task automatic test_range_boundary();
        // pointer is 0 after eight grants wrapping through all four
        req_v     = 4'b1010;
        addr_a[1] = DEPTH - 1;
        addr_a[3] = DEPTH;
        drive();
        #3;
        eval_model();
        n_checks++;
        if (gnt !== 4'b0010 || mem_en !== 1'b1 || mem_addr !== AW'(DEPTH - 1)) begin
            n_fail++;
            $display("FAIL range_first: gnt %b en %b addr %0d expected 0010 1 24099",
                     gnt, mem_en, mem_addr);
        end
        advance();
        req_v = 4'b1000;
        drive();
        #3;
        eval_model();
        n_checks += 2;
        if (gnt !== 4'b1000 || mem_en !== 1'b0 || mem_addr !== AW'(DEPTH)) begin
            n_fail++;
            $display("FAIL range_second: gnt %b en %b addr %0d expected 1000 0 24100",
                     gnt, mem_en, mem_addr);
        end
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_data !== content(DEPTH - 1)) begin
            n_fail++;
            $display("FAIL range_rsp_legal: rv %b err %b data %h expected 0010 0 %h",
                     rsp_valid, rsp_err, rsp_data, content(DEPTH - 1));
        end
        advance();
        req_v = 4'b0000;
        drive();
        #3;
        n_checks++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL range_rsp_err: rv %b err %b data %h expected 1000 1 0",
                     rsp_valid, rsp_err, rsp_data);
        end
        eval_model();
        advance();
    endtask

    task automatic test_wrap();
        // one grant to requester 1 leaves the pointer at 2
        req_v     = 4'b0010;
        addr_a[0] = 100;
        addr_a[1] = 200;
        drive();
        #3;
        eval_model();
        advance();
        n_checks++;
        if (dut.ptr_q !== 2'd2) begin
            n_fail++; $display("FAIL wrap_setup_ptr: got %0d expected 2", dut.ptr_q);
        end
        req_v = 4'b0011;
        drive();
        #3;
        eval_model();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_gnt0: got %b expected 0001", gnt);
        end
        advance();
        #3;
        eval_model();
        n_checks += 2;
        if (dut.ptr_q !== 2'd1) begin
            n_fail++; $display("FAIL wrap_ptr: got %0d expected 1", dut.ptr_q);
        end
        if (gnt !== 4'b0010) begin
            n_fail++; $display("FAIL wrap_gnt1: got %b expected 0010", gnt);
        end
        advance();
        req_v = '0;
        drive();
        #3;
        eval_model();
        advance();
    endtask

    task automatic test_async_reset();
        req_v     = 4'b0101;
        addr_a[0] = 500;
        addr_a[2] = 600;
        drive();
        #3;
        eval_model();
        advance();
        // response now pending; hit reset in the middle of the cycle
        #2;
        reset = 1'b1;
        #1;
        n_checks += 2;
        if (rsp_valid !== 4'b0 || rsp_err !== 1'b0 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL areset_rsp: rv %b err %b data %h expected 0", rsp_valid, rsp_err,
                     rsp_data);
        end
        if (dut.ptr_q !== 2'd0) begin
            n_fail++; $display("FAIL areset_ptr: got %0d expected 0", dut.ptr_q);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #3;
        eval_model();
        n_checks += 2;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL areset_first_gnt: got %b expected 0001", gnt);
        end
        if (rsp_valid !== 4'b0) begin
            n_fail++; $display("FAIL areset_stale: got %b expected 0000", rsp_valid);
        end
        advance();
        req_v = 4'b0000;
        drive();
        #3;
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== content(500)) begin
            n_fail++;
            $display("FAIL areset_rsp_after: rv %b data %h expected 0001 %h", rsp_valid,
                     rsp_data, content(500));
        end
        eval_model();
        advance();
    endtask

    task automatic test_random();
        int wait_cnt[NREQ];
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        req_v = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] && $urandom_range(0, 1) == 1) begin
                    req_v[i] = 1'b1;
                    case ($urandom_range(0, 4))
                        0:       addr_a[i] = 0;
                        1:       addr_a[i] = DEPTH - 1;
                        2:       addr_a[i] = int'($urandom_range(DEPTH, 32767));
                        default: addr_a[i] = int'($urandom_range(0, DEPTH - 1));
                    endcase
                end
            end
            drive();
            #3;
            eval_model();
            n_checks++;
            if (gnt !== e_gnt || mem_en !== e_en || mem_addr !== e_addr ||
                rsp_valid !== m_rv || rsp_err !== m_re || rsp_data !== m_rd ||
                busy !== ((|req_v) || (|m_rv))) begin
                n_fail++;
                $display("FAIL random c%0d: gnt %b/%b en %b/%b addr %0d/%0d rv %b/%b err %b/%b data %h/%h busy %b",
                         c, gnt, e_gnt, mem_en, e_en, mem_addr, e_addr, rsp_valid, m_rv,
                         rsp_err, m_re, rsp_data, m_rd, busy);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (i == e_win) wait_cnt[i] = 0;
                else if (req_v[i] && e_win >= 0) wait_cnt[i]++;
            end
            n_checks++;
            for (int i = 0; i < NREQ; i++) begin
                if (wait_cnt[i] > NREQ - 1) begin
                    n_fail++;
                    $display("FAIL random_starve c%0d: req %0d waited %0d grants", c, i,
                             wait_cnt[i]);
                end
            end
            advance();
            if (e_win >= 0) req_v[e_win] = 1'b0;
        end
        req_v = '0;
        drive();
        #3;
        eval_model();
        advance();
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_addr  = '0;
        mem_rdata = '0;
        req_v     = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_idle();
        test_single();
        test_all_requesters();
        test_range_boundary();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_sample_arbiter.md
Name: rf_sample_arbiter

Overview:
- Shares one synchronous-read RF sample memory port between NREQ beamforming requesters. Typical requesters are per-channel delay/focus units, each fetching samples by index.
- Arbitration is round-robin with a valid/ready handshake. At most one read is issued per cycle.
- Read data returns one cycle later, tagged with a one-hot response valid to the winning requester.
- Sits between the delay-calculation units and the RF sample store, which holds 24100 samples (indices 0..24099).

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 15, sample index width.
- DATA_W, 16, RF sample width.
- MEM_DEPTH, 24100, valid sample count; legal indices are 0..MEM_DEPTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester read request (valid).
- req_addr  input  NREQ*ADDR_W  packed sample indices; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  output  NREQ  one-hot grant (ready), combinational.
- mem_en  output  1  memory read enable, combinational.
- mem_addr  output  ADDR_W  memory read index, combinational.
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en.
- rsp_valid  output  NREQ  one-hot response valid, registered.
- rsp_data  output  DATA_W  response sample.
- rsp_err  output  1  response was out of range, registered.
- busy  output  1  high when any req is asserted or any rsp_valid is high.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - rsp_valid=0, rsp_err=0, priority pointer=0 (requester 0 highest priority).
  - gnt=0, mem_en=0 and mem_addr=0 whenever req=0.
  - Any in-flight response is discarded. No rsp_valid pulse follows reset deassertion.
- Handshake:
  - Requester i holds req[i] and its address stable until it sees gnt[i].
  - A transfer occurs in any cycle where req[i]&gnt[i]=1.
  - A requester may keep req high to issue back-to-back reads at one per cycle when it is the only requester.
- Arbitration (combinational):
  - Search req starting at the pointer, wrapping modulo NREQ. The first asserted requester wins.
  - gnt is one-hot or zero; gnt is never high for a requester whose req is low.
- Pointer update:
  - On a transfer by requester w, the pointer becomes (w+1) mod NREQ on the next edge.
  - With no transfer, the pointer holds.
  - Any requester waits at most NREQ-1 grants.
- Memory issue:
  - mem_addr = winner's address.
  - mem_en = 1 only if a transfer occurs and that address < MEM_DEPTH.
  - When there is no transfer, mem_addr=0.
- Out-of-range address (>= MEM_DEPTH):
  - The request is still granted, so the requester is never stalled.
  - mem_en stays 0.
  - The response carries rsp_data=0 and rsp_err=1.
- Response (latency 1):
  - In cycle T+1 after a transfer in cycle T: rsp_valid = registered gnt, rsp_err = registered out-of-range flag.
  - rsp_data = mem_rdata when rsp_err=0, else 0.
  - rsp_data is 0 whenever rsp_valid=0.
- Throughput: one response per cycle sustained; no internal buffering and no backpressure on responses.
- Address 0 and address MEM_DEPTH-1 (24099) are both legal. No wrap logic is applied to indices; wrapping is the requester's responsibility.
- Simultaneous events:
  - A req rising in the same cycle as another requester's transfer is arbitrated next cycle using the updated pointer.
  - reset asserted in the same cycle as a transfer: the transfer is dropped.

Test Plan:
- Single requester 2, req held 4 cycles, addrs 10,11,12,13:
  - gnt=0100 each cycle; mem_addr follows.
  - rsp_valid=0100 for cycles 1..4 with memory contents at 10..13; pointer ends at 3.
- All four requesters held high after reset, 8 cycles:
  - Grant order 0,1,2,3,0,1,2,3; exactly one gnt bit per cycle.
  - Each rsp_valid bit appears one cycle after its gnt.
- Requester 1 addr 24099, requester 3 addr 24100, both requesting with pointer=0:
  - Requester 1 granted first: mem_en=1, then valid data, rsp_err=0.
  - Requester 3 granted next: mem_en=0, then rsp_valid=1000, rsp_data=0, rsp_err=1.
- Pointer=2, req=0011:
  - Requester 0 granted (wrap), pointer becomes 1.
  - Requester 1 granted next cycle.
- Reset asserted asynchronously mid-cycle while requesters 0 and 2 are active and a response is pending:
  - rsp_valid, rsp_err and pointer clear immediately.
  - After release, the first grant goes to requester 0 and no stale response appears.
- req=0000 for 5 cycles: gnt=0, mem_en=0, rsp_valid=0, busy=0 throughout.
